pps_conditioner: RTL and testbench

Conditioning stage directly upstream of the GPS clock-sync block. It takes the raw receiver PPS, then:
- synchronises it and filters glitches;
- checks each interval against the nominal 1 s period;
- drives a clean, fixed-width PPS to the sync block only after lock;
- generates synthetic pulses (holdover) when the GPS PPS drops out.

---
 rtl/pps_cond_pkg.sv | 28 ++
 rtl/pps_glitch_filter.sv | 41 ++++
 rtl/pps_conditioner.sv | 197 +++++++++++++++++++
 tb/tb_pps_conditioner.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pps_cond_pkg.sv
// Shared types and sizing helpers for the PPS conditioning stage.
package pps_cond_pkg;

  typedef enum logic [1:0] {
    ST_ACQUIRE  = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_HOLDOVER = 2'd2
  } state_t;

  // Interval counter width: must hold the longest acceptable period.
  function automatic int cnt_width(input int freq, input int tol);
    return $clog2(freq + tol + 1);
  endfunction

  // Bits needed to hold 0..value, never less than one.
  function automatic int bits_for(input int value);
    return (value < 1) ? 1 : $clog2(value + 1);
  endfunction

  function automatic logic [31:0] period_lo(input int freq, input int tol);
    return 32'(freq - tol);
  endfunction

  function automatic logic [31:0] period_hi(input int freq, input int tol);
    return 32'(freq + tol);
  endfunction

endpackage

// File: rtl/pps_glitch_filter.sv
// Synchronises the raw PPS and emits a one-cycle qualified edge once the
// level has stayed high for MIN_HIGH_CYCLES consecutive samples.
module pps_glitch_filter
  import pps_cond_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int MIN_HIGH_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic qual_edge
);

  localparam int RW = bits_for(MIN_HIGH_CYCLES + 1);
  localparam logic [RW-1:0] RUN_HIT = RW'(MIN_HIGH_CYCLES);
  localparam logic [RW-1:0] RUN_SAT = RW'(MIN_HIGH_CYCLES + 1);
  localparam logic [RW-1:0] RUN_ONE = RW'(1);

  logic [SYNC_STAGES-1:0] sync;
  logic [RW-1:0]          run;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, as the hardware does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      run  <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], level};
      if (!sync[SYNC_STAGES-1])
        run <= '0;
      else if (run != RUN_SAT)
        run <= run + RUN_ONE;
    end
  end

  // Run count parks one past the hit value so the edge lasts one cycle.
  assign qual_edge = (run == RUN_HIT);

endmodule

// File: rtl/pps_conditioner.sv
// PPS conditioner: glitch filter, period check, lock/holdover FSM and a
// fixed-width registered output pulse for the clock-sync block.
module pps_conditioner
  import pps_cond_pkg::*;
#(
  parameter int SYS_CLK_FREQ    = 100_000_000,
  parameter int SYNC_STAGES     = 2,
  parameter int MIN_HIGH_CYCLES = 16,
  parameter int PERIOD_TOL      = 10_000,
  parameter int LOCK_COUNT      = 3,
  parameter int PULSE_WIDTH     = 100,
  parameter int HOLDOVER_MAX    = 10
) (
  input  logic        SYS_CLK,
  input  logic        RESET_N,
  input  logic        PPS_IN,
  output logic        PPS_OUT,
  output logic        PPS_STROBE,
  output logic        PPS_VALID,
  output logic        HOLDOVER,
  output logic [31:0] PERIOD_CNT
);

  localparam int CW  = cnt_width(SYS_CLK_FREQ, PERIOD_TOL);
  localparam int LW  = bits_for(LOCK_COUNT);
  localparam int HW  = bits_for(HOLDOVER_MAX);
  localparam int PWW = bits_for(PULSE_WIDTH);

  localparam logic [31:0]    PERIOD_LO = period_lo(SYS_CLK_FREQ, PERIOD_TOL);
  localparam logic [31:0]    PERIOD_HI = period_hi(SYS_CLK_FREQ, PERIOD_TOL);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam logic [LW-1:0]  LOCK_LAST = LW'(LOCK_COUNT - 1);
  localparam logic [LW-1:0]  GOOD_ONE  = LW'(1);
  localparam logic [HW-1:0]  HO_MAX    = HW'(HOLDOVER_MAX);
  localparam logic [HW-1:0]  HO_ONE    = HW'(1);
  localparam logic [PWW-1:0] PW_LAST   = PWW'(PULSE_WIDTH - 1);
  localparam logic [PWW-1:0] PW_ONE    = PWW'(1);

  // Async assert, sync deassert of the internal reset.
  logic [1:0] rst_pipe;
  logic       rst_n;

  always_ff @(posedge SYS_CLK or negedge RESET_N) begin
    if (!RESET_N) rst_pipe <= 2'b00;
    else          rst_pipe <= {rst_pipe[0], 1'b1};
  end

  assign rst_n = rst_pipe[1];

  logic qual_edge;

  pps_glitch_filter #(
    .SYNC_STAGES    (SYNC_STAGES),
    .MIN_HIGH_CYCLES(MIN_HIGH_CYCLES)
  ) u_filter (
    .clk      (SYS_CLK),
    .rst_n    (rst_n),
    .level    (PPS_IN),
    .qual_edge(qual_edge)
  );

  state_t         state, state_next;
  logic [CW-1:0]  cnt;
  logic [LW-1:0]  good_cnt, good_next;
  logic [HW-1:0]  ho_cnt, ho_next;
  logic [PWW-1:0] pw_cnt;
  logic           started, started_next;
  logic [31:0]    period_next;
  logic           emit, cnt_clr;

  logic [31:0] p;
  logic        good, timeout, due;

  assign p       = 32'(cnt) + 32'd1;
  assign good    = (p >= PERIOD_LO) && (p <= PERIOD_HI);
  assign timeout = (p == PERIOD_HI) && !qual_edge;
  assign due     = (p == PERIOD_CNT);

  // NOTE: every signal written here gets a default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next   = state;
    good_next    = good_cnt;
    ho_next      = ho_cnt;
    started_next = started;
    period_next  = PERIOD_CNT;
    emit         = 1'b0;
    cnt_clr      = qual_edge;
    case (state)
      ST_ACQUIRE: begin
        if (qual_edge) begin
          started_next = 1'b1;
          if (started) begin
            if (good) begin
              period_next = p;
              if (good_cnt == LOCK_LAST) begin
                state_next = ST_LOCKED;
                good_next  = '0;
                emit       = 1'b1;
              end else begin
                good_next = good_cnt + GOOD_ONE;
              end
            end else begin
              good_next = '0;
            end
          end
        end
      end
      ST_LOCKED: begin
        if (qual_edge) begin
          if (good) begin
            emit        = 1'b1;
            period_next = p;
          end else begin
            state_next   = ST_ACQUIRE;
            good_next    = '0;
            started_next = 1'b1;
          end
        end else if (timeout) begin
          if (HOLDOVER_MAX > 0) begin
            state_next = ST_HOLDOVER;
            emit       = 1'b1;
            cnt_clr    = 1'b1;
            ho_next    = HO_ONE;
          end else begin
            state_next   = ST_ACQUIRE;
            good_next    = '0;
            started_next = 1'b0;
          end
        end
      end
      ST_HOLDOVER: begin
        if (qual_edge) begin
          state_next   = ST_ACQUIRE;
          good_next    = '0;
          started_next = 1'b1;
        end else if (due) begin
          if (ho_cnt == HO_MAX) begin
            state_next   = ST_ACQUIRE;
            good_next    = '0;
            started_next = 1'b0;
          end else begin
            emit    = 1'b1;
            cnt_clr = 1'b1;
            ho_next = ho_cnt + HO_ONE;
          end
        end
      end
      default: state_next = ST_ACQUIRE;
    endcase
  end

  always_ff @(posedge SYS_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_ACQUIRE;
      cnt        <= '0;
      good_cnt   <= '0;
      ho_cnt     <= '0;
      started    <= 1'b0;
      PERIOD_CNT <= '0;
      PPS_VALID  <= 1'b0;
      HOLDOVER   <= 1'b0;
    end else begin
      state      <= state_next;
      good_cnt   <= good_next;
      ho_cnt     <= ho_next;
      started    <= started_next;
      PERIOD_CNT <= period_next;
      PPS_VALID  <= (state_next != ST_ACQUIRE);
      HOLDOVER   <= (state_next == ST_HOLDOVER);
      if (cnt_clr)
        cnt <= '0;
      else if (cnt != '1)
        cnt <= cnt + CNT_ONE;
    end
  end

  // Pulse generator: a new emit restarts the width count.
  always_ff @(posedge SYS_CLK or negedge rst_n) begin
    if (!rst_n) begin
      PPS_OUT    <= 1'b0;
      PPS_STROBE <= 1'b0;
      pw_cnt     <= '0;
    end else begin
      PPS_STROBE <= emit;
      if (emit) begin
        PPS_OUT <= 1'b1;
        pw_cnt  <= PW_LAST;
      end else if (pw_cnt != '0) begin
        pw_cnt <= pw_cnt - PW_ONE;
      end else begin
        PPS_OUT <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pps_conditioner.sv
// Directed bench for pps_conditioner with a 1000-cycle nominal period.
module tb_pps_conditioner;

  localparam int FREQ  = 1000;
  localparam int TOL   = 10;
  localparam int MINH  = 4;
  localparam int LOCKN = 3;
  localparam int PW    = 8;
  localparam int HOMAX = 2;
  localparam int SYNC  = 2;

  logic        SYS_CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        PPS_IN  = 1'b0;
  logic        PPS_OUT, PPS_STROBE, PPS_VALID, HOLDOVER;
  logic [31:0] PERIOD_CNT;

  always #5 SYS_CLK = ~SYS_CLK;

  pps_conditioner #(
    .SYS_CLK_FREQ   (FREQ),
    .SYNC_STAGES    (SYNC),
    .MIN_HIGH_CYCLES(MINH),
    .PERIOD_TOL     (TOL),
    .LOCK_COUNT     (LOCKN),
    .PULSE_WIDTH    (PW),
    .HOLDOVER_MAX   (HOMAX)
  ) dut (
    .SYS_CLK   (SYS_CLK),
    .RESET_N   (RESET_N),
    .PPS_IN    (PPS_IN),
    .PPS_OUT   (PPS_OUT),
    .PPS_STROBE(PPS_STROBE),
    .PPS_VALID (PPS_VALID),
    .HOLDOVER  (HOLDOVER),
    .PERIOD_CNT(PERIOD_CNT)
  );

  typedef struct {
    int   len;
    int   width;
    int   d_strobe;
    logic valid;
    logic ho;
    int   period;
  } seg_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int last_strobe = 0;
  int hi_run = 0;
  int last_width = 0;
  int last_rise = 0;

  // Monitor: samples outputs 1 time unit after each rising edge.
  always @(posedge SYS_CLK) begin
    cyc = cyc + 1;
    #1;
    if (PPS_STROBE) begin
      strobe_cnt  = strobe_cnt + 1;
      last_strobe = cyc;
    end
    if (PPS_OUT) begin
      hi_run = hi_run + 1;
    end else if (hi_run > 0) begin
      last_width = hi_run;
      hi_run     = 0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One PPS_IN rise of the given width, then low until len cycles elapse.
  task automatic send_pps(input int len, input int width);
    for (int i = 0; i < len; i++) begin
      @(negedge SYS_CLK);
      PPS_IN = (i < width);
      if (i == 0) last_rise = cyc + 1;
    end
  endtask

  task automatic wait_strobe(input string name, input int max_cycles, output int at);
    at = -1;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge SYS_CLK);
      if (PPS_STROBE) begin
        at = cyc;
        break;
      end
    end
    check({name, "_seen"}, int'(at >= 0), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    seg_t segs[9];
    int   sc, s0, s1, s2;

    segs[0] = '{500,  50, 1, 1'b1, 1'b0, 1000};
    segs[1] = '{500,   3, 0, 1'b1, 1'b0, 1000};
    segs[2] = '{990,  50, 1, 1'b1, 1'b0, 1000};
    segs[3] = '{1010, 50, 1, 1'b1, 1'b0, 990};
    segs[4] = '{989,  50, 1, 1'b1, 1'b0, 1010};
    segs[5] = '{1000, 50, 0, 1'b0, 1'b0, 1010};
    segs[6] = '{1000, 50, 0, 1'b0, 1'b0, 1000};
    segs[7] = '{1000, 50, 0, 1'b0, 1'b0, 1000};
    segs[8] = '{1000, 50, 1, 1'b1, 1'b0, 1000};

    // Reset state
    repeat (3) @(negedge SYS_CLK);
    check("rst_out",    PPS_OUT,    0);
    check("rst_strobe", PPS_STROBE, 0);
    check("rst_valid",  PPS_VALID,  0);
    check("rst_ho",     HOLDOVER,   0);
    check("rst_period", PERIOD_CNT, 0);
    RESET_N = 1'b1;
    repeat (10) @(negedge SYS_CLK);

    // Initial lock
    for (int k = 0; k < 3; k++) send_pps(1000, 50);
    check("acq_no_strobe", strobe_cnt, 0);
    check("acq_valid",     PPS_VALID,  0);
    check("acq_period",    PERIOD_CNT, 1000);
    send_pps(1000, 50);
    check("lock_strobes",  strobe_cnt, 1);
    check("lock_latency",  last_strobe - last_rise, 6);
    check("lock_width",    last_width, PW);
    check("lock_valid",    PPS_VALID,  1);
    check("lock_ho",       HOLDOVER,   0);
    check("lock_period",   PERIOD_CNT, 1000);

    // Glitch, tolerance edges, drop and re-lock
    for (int i = 0; i < 9; i++) begin
      sc = strobe_cnt;
      send_pps(segs[i].len, segs[i].width);
      check($sformatf("seg%0d_strobes", i), strobe_cnt - sc, segs[i].d_strobe);
      check($sformatf("seg%0d_valid", i),   PPS_VALID,       int'(segs[i].valid));
      check($sformatf("seg%0d_ho", i),      HOLDOVER,        int'(segs[i].ho));
      check($sformatf("seg%0d_period", i),  PERIOD_CNT,      segs[i].period);
    end

    // Holdover: PPS_IN stays low after lock
    s0 = last_strobe;
    wait_strobe("ho1", 1200, s1);
    check("ho1_spacing", s1 - s0, 1010);
    check("ho1_flag",    HOLDOVER,  1);
    check("ho1_valid",   PPS_VALID, 1);
    wait_strobe("ho2", 1200, s2);
    check("ho2_spacing", s2 - s1, 1000);
    check("ho2_flag",    HOLDOVER,  1);
    sc = strobe_cnt;
    while (cyc < s2 + 999) @(negedge SYS_CLK);
    check("ho_before_expire_valid", PPS_VALID, 1);
    @(negedge SYS_CLK);
    check("ho_expire_valid",  PPS_VALID,  0);
    check("ho_expire_flag",   HOLDOVER,   0);
    check("ho_expire_strobe", strobe_cnt, sc);
    repeat (50) @(negedge SYS_CLK);
    check("ho_expire_quiet",  strobe_cnt, sc);

    // Recovery: E during holdover, then three good periods
    for (int k = 0; k < 4; k++) send_pps(1000, 50);
    check("rec_lock_valid", PPS_VALID, 1);
    wait_strobe("rec_ho", 1200, s1);
    check("rec_ho_flag", HOLDOVER, 1);
    repeat (300) @(negedge SYS_CLK);
    sc = strobe_cnt;
    send_pps(1000, 50);
    check("rec_e_strobe", strobe_cnt - sc, 0);
    check("rec_e_valid",  PPS_VALID, 0);
    check("rec_e_ho",     HOLDOVER,  0);
    send_pps(1000, 50);
    send_pps(1000, 50);
    check("rec_2good_strobe", strobe_cnt - sc, 0);
    check("rec_2good_valid",  PPS_VALID, 0);
    send_pps(1000, 50);
    check("rec_relock_strobe", strobe_cnt - sc, 1);
    check("rec_relock_valid",  PPS_VALID, 1);

    // Async reset in the middle of an output pulse
    @(negedge SYS_CLK);
    PPS_IN = 1'b1;
    last_rise = cyc + 1;
    while (cyc < last_rise + 8) @(negedge SYS_CLK);
    check("midpulse_out_high", PPS_OUT, 1);
    #2 RESET_N = 1'b0;
    #1;
    check("midrst_out",    PPS_OUT,    0);
    check("midrst_strobe", PPS_STROBE, 0);
    check("midrst_valid",  PPS_VALID,  0);
    check("midrst_ho",     HOLDOVER,   0);
    check("midrst_period", PERIOD_CNT, 0);
    @(negedge SYS_CLK);
    PPS_IN = 1'b0;
    repeat (3) @(negedge SYS_CLK);
    RESET_N = 1'b1;
    repeat (10) @(negedge SYS_CLK);
    sc = strobe_cnt;
    for (int k = 0; k < 3; k++) send_pps(1000, 50);
    check("postrst_3_strobe", strobe_cnt - sc, 0);
    check("postrst_3_valid",  PPS_VALID, 0);
    send_pps(1000, 50);
    check("postrst_4_strobe", strobe_cnt - sc, 1);
    check("postrst_4_valid",  PPS_VALID, 1);
    check("postrst_period",   PERIOD_CNT, 1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
